// File: rtl/redux_pkg.sv
// Shared definitions for the redux accumulator core: opcodes, control states
// and instruction length decode.
package redux_pkg;

    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_LDI  = 8'h01;
    localparam logic [7:0] OP_LD   = 8'h02;
    localparam logic [7:0] OP_ST   = 8'h03;
    localparam logic [7:0] OP_ADD  = 8'h04;
    localparam logic [7:0] OP_SUB  = 8'h05;
    localparam logic [7:0] OP_AND  = 8'h06;
    localparam logic [7:0] OP_OR   = 8'h07;
    localparam logic [7:0] OP_XOR  = 8'h08;
    localparam logic [7:0] OP_JMP  = 8'h09;
    localparam logic [7:0] OP_JZ   = 8'h0A;
    localparam logic [7:0] OP_JNZ  = 8'h0B;
    localparam logic [7:0] OP_JC   = 8'h0C;
    localparam logic [7:0] OP_OUT  = 8'h0D;
    localparam logic [7:0] OP_IN   = 8'h0E;
    localparam logic [7:0] OP_HALT = 8'hFF;

    typedef enum logic [2:0] {RD0, RD1, RD2, EXEC, HALT} state_t;

    // Index of the final byte of an instruction (0 = opcode only).
    function automatic logic [1:0] last_idx(input logic [7:0] op);
        case (op)
            OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_OUT, OP_IN:
                last_idx = 2'd1;
            OP_LD, OP_ST, OP_JMP, OP_JZ, OP_JNZ, OP_JC:
                last_idx = 2'd3;
            default:
                last_idx = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/redux_alu.sv
// Combinational accumulator datapath: loads, add/sub with carry/borrow and
// bitwise logic; carry passes through for everything but ADD/SUB.
module redux_alu
    import redux_pkg::*;
(
    input  logic [7:0] op_i,
    input  logic [7:0] a_i,
    input  logic [7:0] imm_i,
    input  logic       c_i,
    output logic [7:0] res_o,
    output logic       c_o,
    output logic       z_o
);

    always_comb begin
        res_o = a_i;
        c_o   = c_i;
        case (op_i)
            OP_LDI, OP_LD, OP_IN: res_o = imm_i;
            OP_ADD:               {c_o, res_o} = {1'b0, a_i} + {1'b0, imm_i};
            OP_SUB:               {c_o, res_o} = {1'b0, a_i} - {1'b0, imm_i};
            OP_AND:               res_o = a_i & imm_i;
            OP_OR:                res_o = a_i | imm_i;
            OP_XOR:               res_o = a_i ^ imm_i;
            default:              ;
        endcase
    end

    assign z_o = (res_o == 8'h00);

endmodule

// File: rtl/redux.sv
// redux core: byte-serial fetch over a 3-cycle memory read, one EXEC cycle per
// instruction, accumulator + Z/C flags, numbered 32-bit I/O port.
module redux
    import redux_pkg::*;
(
    input  logic        clock,
    input  logic        locked,
    output logic [19:0] address,
    input  logic [7:0]  din,
    output logic [7:0]  dout,
    output logic        we,
    output logic [7:0]  reg_n,
    input  logic [31:0] reg_i,
    output logic [31:0] reg_o
);

    state_t      state_q, state_d;
    logic [19:0] pc_q, pc_d;
    logic [7:0]  a_q, a_d;
    logic        z_q, z_d, c_q, c_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        ph_q, ph_d;
    logic [7:0]  op_q, op_d, b1_q, b1_d, b2_q, b2_d;
    logic [3:0]  b3_q, b3_d;
    logic [19:0] address_q, address_d;
    logic [7:0]  dout_q, dout_d;
    logic        we_q, we_d;
    logic [7:0]  reg_n_q, reg_n_d;
    logic [31:0] reg_o_q, reg_o_d;

    logic [7:0]  cur_op;
    logic        taken;
    logic [19:0] jmp_tgt, next_pc;
    logic [7:0]  alu_imm, alu_res;
    logic        alu_c, alu_z;
    logic        unused_in;

    assign jmp_tgt   = {b3_q, b2_q, b1_q};
    assign alu_imm   = (op_q == OP_IN) ? reg_i[7:0] : b1_q;
    assign unused_in = ^reg_i[31:8];

    redux_alu u_alu (
        .op_i  (op_q),
        .a_i   (a_q),
        .imm_i (alu_imm),
        .c_i   (c_q),
        .res_o (alu_res),
        .c_o   (alu_c),
        .z_o   (alu_z)
    );

    // Reset parks the core in EXEC of an implicit NOP so the first edge fetches address 0.
    always_ff @(posedge clock or negedge locked) begin
        if (!locked) begin
            state_q   <= EXEC;
            pc_q      <= '0;
            a_q       <= '0;
            z_q       <= 1'b0;
            c_q       <= 1'b0;
            cnt_q     <= '0;
            ph_q      <= 1'b0;
            op_q      <= OP_NOP;
            b1_q      <= '0;
            b2_q      <= '0;
            b3_q      <= '0;
            address_q <= '0;
            dout_q    <= '0;
            we_q      <= 1'b0;
            reg_n_q   <= '0;
            reg_o_q   <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            a_q       <= a_d;
            z_q       <= z_d;
            c_q       <= c_d;
            cnt_q     <= cnt_d;
            ph_q      <= ph_d;
            op_q      <= op_d;
            b1_q      <= b1_d;
            b2_q      <= b2_d;
            b3_q      <= b3_d;
            address_q <= address_d;
            dout_q    <= dout_d;
            we_q      <= we_d;
            reg_n_q   <= reg_n_d;
            reg_o_q   <= reg_o_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        a_d       = a_q;
        z_d       = z_q;
        c_d       = c_q;
        cnt_d     = cnt_q;
        ph_d      = ph_q;
        op_d      = op_q;
        b1_d      = b1_q;
        b2_d      = b2_q;
        b3_d      = b3_q;
        address_d = address_q;
        dout_d    = dout_q;
        we_d      = 1'b0;
        reg_n_d   = reg_n_q;
        reg_o_d   = reg_o_q;
        cur_op    = (cnt_q == 2'd0) ? din : op_q;

        case (op_q)
            OP_JMP:  taken = 1'b1;
            OP_JZ:   taken = z_q;
            OP_JNZ:  taken = !z_q;
            OP_JC:   taken = c_q;
            default: taken = 1'b0;
        endcase
        next_pc = taken ? jmp_tgt : pc_q;

        case (state_q)
            RD0: state_d = RD1;
            RD1: state_d = RD2;
            RD2: begin
                if (ph_q) begin
                    // LD data byte has arrived
                    b1_d    = din;
                    ph_d    = 1'b0;
                    state_d = EXEC;
                end else begin
                    case (cnt_q)
                        2'd0:    op_d = din;
                        2'd1:    b1_d = din;
                        2'd2:    b2_d = din;
                        default: b3_d = din[3:0];
                    endcase
                    if (cnt_q == last_idx(cur_op)) begin
                        cnt_d   = 2'd0;
                        state_d = EXEC;
                        if (cur_op == OP_ST) begin
                            address_d = {din[3:0], b2_q, b1_q};
                            dout_d    = a_q;
                            we_d      = 1'b1;
                        end else if (cur_op == OP_LD) begin
                            address_d = {din[3:0], b2_q, b1_q};
                            ph_d      = 1'b1;
                            state_d   = RD0;
                        end else if (cur_op == OP_IN) begin
                            // port number goes out one cycle before reg_i is sampled
                            reg_n_d = din;
                            ph_d    = 1'b1;
                        end
                    end else begin
                        cnt_d     = cnt_q + 2'd1;
                        address_d = pc_q;
                        pc_d      = pc_q + 20'd1;
                        state_d   = RD0;
                    end
                end
            end
            EXEC: begin
                if (ph_q) begin
                    ph_d = 1'b0;
                end else if (op_q == OP_HALT) begin
                    state_d = HALT;
                end else begin
                    state_d   = RD0;
                    address_d = next_pc;
                    pc_d      = next_pc + 20'd1;
                    case (op_q)
                        OP_LDI, OP_LD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_IN: begin
                            a_d = alu_res;
                            c_d = alu_c;
                            z_d = alu_z;
                        end
                        OP_OUT: begin
                            reg_n_d = b1_q;
                            reg_o_d = {24'h0, a_q};
                        end
                        default: ;
                    endcase
                end
            end
            default: state_d = HALT;
        endcase
    end

    assign address = address_q;
    assign dout    = dout_q;
    assign we      = we_q;
    assign reg_n   = reg_n_q;
    assign reg_o   = reg_o_q;

endmodule

// File: tb/tb_redux.sv
// Bench for redux: two-stage read memory model, program vector table and an
// event scoreboard for memory writes and I/O port updates.
module tb_redux;

    logic        clock = 1'b0;
    logic        locked;
    logic [19:0] address;
    logic [7:0]  din, dout;
    logic        we;
    logic [7:0]  reg_n;
    logic [31:0] reg_i, reg_o;

    redux dut (
        .clock   (clock),
        .locked  (locked),
        .address (address),
        .din     (din),
        .dout    (dout),
        .we      (we),
        .reg_n   (reg_n),
        .reg_i   (reg_i),
        .reg_o   (reg_o)
    );

    always #5 clock = ~clock;

    // Memory: samples address at an edge, data appears two edges later.
    logic [7:0]  mem [0:20'hFFFFF];
    logic [7:0]  rd1 = 8'h00, rd2 = 8'h00;
    logic        ld_en = 1'b0;
    logic [19:0] ld_addr = '0;
    logic [7:0]  ld_data = '0;

    always @(posedge clock) begin
        if (ld_en) mem[ld_addr] <= ld_data;
        else if (we) mem[address] <= dout;
        rd1 <= mem[address];
        rd2 <= rd1;
    end
    assign din = rd2;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    logic [39:0] ioq[$];
    logic [27:0] wq[$];
    logic [39:0] prev_io = '0;

    always @(negedge clock) begin
        if (locked) begin
            if (we) begin
                if (wq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: addr %h data %h, no write expected", address, dout);
                end else begin
                    chk("write", {36'h0, address, dout}, {36'h0, wq.pop_front()});
                end
            end
            if ({reg_n, reg_o} !== prev_io) begin
                if (ioq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_io: reg_n %h reg_o %h, no update expected", reg_n, reg_o);
                end else begin
                    chk("io_update", {24'h0, reg_n, reg_o}, {24'h0, ioq.pop_front()});
                end
            end
        end
        prev_io = {reg_n, reg_o};
    end

    logic [7:0] img [64];

    task automatic load_mem();
        for (int a = 0; a < 64; a++) begin
            ld_addr = a[19:0];
            ld_data = img[a];
            ld_en   = 1'b1;
            @(negedge clock);
        end
        ld_addr = 20'h12345;
        ld_data = 8'h00;
        @(negedge clock);
        ld_en = 1'b0;
    endtask

    task automatic wait_halt(input string nm);
        int stable = 0;
        logic [19:0] last;
        last = address;
        for (int c = 0; c < 1000 && stable < 12; c++) begin
            @(negedge clock);
            if (address == last) stable++;
            else stable = 0;
            last = address;
        end
        if (stable < 12) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: address %h still moving, expected halt", nm, address);
        end
    endtask

    typedef struct {
        logic [0:15][7:0] s0;
        logic [19:0]      base1;
        logic [0:3][7:0]  s1;
        logic [31:0]      rin;
        int               nio;
        logic [39:0]      io0;
        logic [39:0]      io1;
        logic             wr;
        logic [27:0]      wrv;
        logic [19:0]      halt;
    } vec_t;

    localparam int NV = 9;
    vec_t vt [NV];

    initial begin
        vt[0] = '{s0: {8'h01, 8'h05, 8'h04, 8'h03, 8'h0D, 8'h07, 8'hFF, {9{8'h00}}},
                  base1: 20'h30, s1: 32'h0, rin: 32'h0, nio: 1, io0: {8'h07, 32'h8},
                  io1: 40'h0, wr: 1'b0, wrv: 28'h0, halt: 20'h06};
        vt[1] = '{s0: {8'h01, 8'hFF, 8'h04, 8'h01, 8'h0C, 8'h10, 8'h00, 8'h00, {8{8'h00}}},
                  base1: 20'h10, s1: 32'h0D01FF00, rin: 32'h0, nio: 1, io0: {8'h01, 32'h0},
                  io1: 40'h0, wr: 1'b0, wrv: 28'h0, halt: 20'h12};
        vt[2] = '{s0: {8'h01, 8'hFF, 8'h04, 8'h01, 8'h0A, 8'h10, 8'h00, 8'h00, {8{8'h00}}},
                  base1: 20'h10, s1: 32'h0D01FF00, rin: 32'h0, nio: 1, io0: {8'h01, 32'h0},
                  io1: 40'h0, wr: 1'b0, wrv: 28'h0, halt: 20'h12};
        vt[3] = '{s0: {8'h01, 8'hA5, 8'h03, 8'h45, 8'h23, 8'h01, 8'h01, 8'h00,
                       8'h02, 8'h45, 8'h23, 8'h01, 8'h0D, 8'h02, 8'hFF, 8'h00},
                  base1: 20'h30, s1: 32'h0, rin: 32'h0, nio: 1, io0: {8'h02, 32'hA5},
                  io1: 40'h0, wr: 1'b1, wrv: {20'h12345, 8'hA5}, halt: 20'h0E};
        vt[4] = '{s0: {8'h0E, 8'h03, 8'h0A, 8'h20, 8'h00, 8'h00, 8'h0D, 8'h05, 8'hFF, {7{8'h00}}},
                  base1: 20'h20, s1: 32'h0D04FF00, rin: 32'h0, nio: 2, io0: {8'h03, 32'h0},
                  io1: {8'h04, 32'h0}, wr: 1'b0, wrv: 28'h0, halt: 20'h22};
        vt[5] = '{s0: {8'h0E, 8'h03, 8'h0A, 8'h20, 8'h00, 8'h00, 8'h0D, 8'h05, 8'hFF, {7{8'h00}}},
                  base1: 20'h20, s1: 32'h0D04FF00, rin: 32'hABCDEF12, nio: 2, io0: {8'h03, 32'h0},
                  io1: {8'h05, 32'h12}, wr: 1'b0, wrv: 28'h0, halt: 20'h08};
        vt[6] = '{s0: {8'h01, 8'h03, 8'h05, 8'h05, 8'h0C, 8'h10, 8'h00, 8'h00, {8{8'h00}}},
                  base1: 20'h10, s1: 32'h0D09FF00, rin: 32'h0, nio: 1, io0: {8'h09, 32'hFE},
                  io1: 40'h0, wr: 1'b0, wrv: 28'h0, halt: 20'h12};
        vt[7] = '{s0: {8'h01, 8'hF0, 8'h07, 8'h0F, 8'h08, 8'hFF, 8'h06, 8'h3C,
                       8'h0B, 8'h10, 8'h00, 8'h00, 8'h0D, 8'h0A, 8'hFF, 8'h00},
                  base1: 20'h10, s1: 32'h0D0BFF00, rin: 32'h0, nio: 1, io0: {8'h0A, 32'h0},
                  io1: 40'h0, wr: 1'b0, wrv: 28'h0, halt: 20'h0E};
        vt[8] = '{s0: {8'h01, 8'h10, 8'h04, 8'h20, 8'h0C, 8'h10, 8'h00, 8'h00,
                       8'h0D, 8'h0C, 8'hFF, {5{8'h00}}},
                  base1: 20'h10, s1: 32'h0D0DFF00, rin: 32'h0, nio: 1, io0: {8'h0C, 32'h30},
                  io1: 40'h0, wr: 1'b0, wrv: 28'h0, halt: 20'h0A};

        // Reset and first fetch over an all-NOP image
        locked = 1'b0;
        reg_i  = 32'h0;
        for (int a = 0; a < 64; a++) img[a] = 8'h00;
        @(negedge clock);
        load_mem();
        repeat (5) @(negedge clock);
        chk("rst_address", {44'h0, address}, 64'h0);
        chk("rst_we", {63'h0, we}, 64'h0);
        chk("rst_dout", {56'h0, dout}, 64'h0);
        chk("rst_reg_n", {56'h0, reg_n}, 64'h0);
        chk("rst_reg_o", {32'h0, reg_o}, 64'h0);
        locked = 1'b1;
        @(posedge clock); #1;
        chk("first_fetch_addr", {44'h0, address}, 64'h0);
        chk("first_fetch_we", {63'h0, we}, 64'h0);
        repeat (3) @(posedge clock); #1;
        chk("nop_addr_e4", {44'h0, address}, 64'h0);
        @(posedge clock); #1;
        chk("nop_addr_e5", {44'h0, address}, 64'h1);
        repeat (4) @(posedge clock); #1;
        chk("nop_addr_e9", {44'h0, address}, 64'h2);

        // Program table
        for (int i = 0; i < NV; i++) begin
            @(negedge clock); #1;
            locked = 1'b0;
            for (int a = 0; a < 64; a++) img[a] = 8'h00;
            for (int j = 0; j < 16; j++) img[j] = vt[i].s0[j];
            for (int j = 0; j < 4; j++) img[int'(vt[i].base1) + j] = vt[i].s1[j];
            load_mem();
            reg_i = vt[i].rin;
            ioq.delete();
            wq.delete();
            ioq.push_back(vt[i].io0);
            if (vt[i].nio == 2) ioq.push_back(vt[i].io1);
            if (vt[i].wr) wq.push_back(vt[i].wrv);
            @(negedge clock);
            locked = 1'b1;
            wait_halt($sformatf("v%0d", i));
            chk($sformatf("v%0d_halt_addr", i), {44'h0, address}, {44'h0, vt[i].halt});
            chk($sformatf("v%0d_io_pending", i), 64'(ioq.size()), 64'h0);
            chk($sformatf("v%0d_wr_pending", i), 64'(wq.size()), 64'h0);
            chk($sformatf("v%0d_we_idle", i), {63'h0, we}, 64'h0);
        end

        // Reset during ST EXEC drops the write
        begin
            int n;
            @(negedge clock); #1;
            locked = 1'b0;
            for (int a = 0; a < 64; a++) img[a] = 8'h00;
            img[0] = 8'h01; img[1] = 8'hA5; img[2] = 8'h03; img[3] = 8'h45;
            img[4] = 8'h23; img[5] = 8'h01; img[6] = 8'hFF;
            load_mem();
            ioq.delete();
            wq.delete();
            wq.push_back({20'h12345, 8'hA5});
            @(negedge clock);
            locked = 1'b1;
            n = 0;
            while (we !== 1'b1 && n < 100) begin
                @(posedge clock); #1;
                n++;
            end
            chk("st_we_edge", 64'(n), 64'd20);
            @(negedge clock); #1;
            locked = 1'b0;
            #1;
            chk("abort_we", {63'h0, we}, 64'h0);
            chk("abort_address", {44'h0, address}, 64'h0);
            chk("abort_dout", {56'h0, dout}, 64'h0);
            @(posedge clock); #1;
            chk("abort_mem", {56'h0, mem[20'h12345]}, 64'h0);
            wq.push_back({20'h12345, 8'hA5});
            @(negedge clock);
            locked = 1'b1;
            @(posedge clock); #1;
            chk("restart_addr", {44'h0, address}, 64'h0);
            wait_halt("restart");
            chk("restart_halt_addr", {44'h0, address}, 64'h6);
            chk("restart_wr_pending", 64'(wq.size()), 64'h0);
            chk("restart_mem", {56'h0, mem[20'h12345]}, 64'hA5);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
